// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT sequencing controller and its
// butterfly datapath.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_state_t;

    localparam int LOG2N_DEF  = 6;
    localparam int BF_LAT_DEF = 3;

    // Butterfly datapath widths; twiddle factors are Q13 fixed point.
    localparam int DATA_W    = 24;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 13;

endpackage

// File: rtl/fft_addr_fifo.sv
// Small synchronous FIFO that holds the (p,q) write-back address pairs of
// butterflies still in flight.
module fft_addr_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_ctrl.sv
// FFT sequencing controller: walks the radix-2 DIT stages, issues one
// butterfly read per cycle and drains in-flight write-backs between stages.
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = BF_LAT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_p,
    output logic [LOG2N-1:0] rd_addr_q,
    output logic [LOG2N-2:0] tw_idx,
    output logic             bf_en,
    input  logic             bf_valid,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_p,
    output logic [LOG2N-1:0] wr_addr_q,
    output logic             err
);
    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_RUN   | issuing one butterfly read per cycle, increasing b
    // ST_DRAIN | reads stopped, waiting for all write-backs of the stage
    // ST_DONE  | one-cycle completion pulse

    localparam int OW         = $clog2(BF_LAT + 2);
    localparam int FIFO_DEPTH = BF_LAT + 2;

    fft_state_t         state;
    fft_state_t         state_nx;
    logic [LOG2N-2:0]   b;
    logic [OW-1:0]      outst;
    logic [OW-1:0]      outst_nx;
    logic               stage_clr;
    logic               stage_inc;

    logic [LOG2N-1:0]   b_ext;
    logic [LOG2N-1:0]   h;
    logic [LOG2N-1:0]   pos;
    logic [LOG2N-1:0]   p_addr;
    logic [LOG2N-1:0]   q_addr;
    logic [3:0]         tw_sh;
    logic [LOG2N-2:0]   tw_full;

    logic [2*LOG2N-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    assign b_ext   = {1'b0, b};
    assign h       = LOG2N'(1) << stage;
    assign pos     = b_ext & (h - LOG2N'(1));
    assign p_addr  = ((b_ext >> stage) << (stage + 4'd1)) | pos;
    assign q_addr  = p_addr | h;
    // pos < 2^stage, so the shifted index always fits in LOG2N-1 bits
    assign tw_sh   = 4'(LOG2N - 1) - stage;
    assign tw_full = pos[LOG2N-2:0] << tw_sh;

    assign rd_addr_p = rd_en ? p_addr : '0;
    assign rd_addr_q = rd_en ? q_addr : '0;
    assign tw_idx    = rd_en ? tw_full : '0;
    assign busy      = (state != ST_IDLE);
    assign wr_en     = bf_valid && !fifo_empty;
    assign outst_nx  = outst + OW'(rd_en) - OW'(wr_en);

    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        stage_clr = 1'b0;
        stage_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx  = ST_RUN;
                    stage_clr = 1'b1;
                end
            end
            ST_RUN: begin
                rd_en = 1'b1;
                if (&b) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle of the final write so the next read follows it directly.
                if (outst_nx == '0) begin
                    if (stage == 4'(LOG2N - 1)) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx  = ST_RUN;
                        stage_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                stage_clr = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            stage <= '0;
            b     <= '0;
            outst <= '0;
            bf_en <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            outst <= outst_nx;
            bf_en <= rd_en;
            if (stage_clr) begin
                stage <= '0;
                b     <= '0;
            end else begin
                if (stage_inc) begin
                    stage <= stage + 4'd1;
                end
                // b wraps to 0 after the last butterfly, ready for the next stage
                if (rd_en) begin
                    b <= b + (LOG2N - 1)'(1);
                end
            end
            if ((bf_valid && fifo_empty) || (rd_en && fifo_full && !wr_en)) begin
                err <= 1'b1;
            end
        end
    end

    fft_addr_fifo #(
        .WIDTH (2 * LOG2N),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rd_en),
        .pop   (wr_en),
        .din   ({p_addr, q_addr}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {wr_addr_p, wr_addr_q} = fifo_dout;

endmodule
